// File: rtl/regfile_sb_if.sv
// Bundle for the scoreboarded register file: writeback, read ports, reservation and status.
interface regfile_sb_if #(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  parameter int NRD  = 2
);
  localparam int AW = $clog2(NREG);
  localparam int CW = $clog2(NREG + 1);

  logic                wr_en;
  logic [AW-1:0]       wr_addr;
  logic [XLEN-1:0]     wr_data;
  logic [NRD*AW-1:0]   rd_addr;
  logic [NRD*XLEN-1:0] rd_data;
  logic [NRD-1:0]      rd_busy;
  logic                rsv_en;
  logic [AW-1:0]       rsv_addr;
  logic                rsv_ok;
  logic [NREG-1:0]     busy_vec;
  logic [CW-1:0]       busy_cnt;

  modport master (
    output wr_en, wr_addr, wr_data, rd_addr, rsv_en, rsv_addr,
    input  rd_data, rd_busy, rsv_ok, busy_vec, busy_cnt
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, rd_addr, rsv_en, rsv_addr,
    output rd_data, rd_busy, rsv_ok, busy_vec, busy_cnt
  );
endinterface

// File: rtl/regfile_sb.sv
// Register file with busy scoreboard: combinational reads with writeback bypass, x0 hardwired zero.
// A reservation marks a destination pending until its writeback; reservation wins a same-edge tie.
module regfile_sb #(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  parameter int NRD  = 2
) (
  input  logic         clk,
  input  logic         rst,
  regfile_sb_if.slave  bus
);
  localparam int AW = $clog2(NREG);
  localparam int CW = $clog2(NREG + 1);

  logic [XLEN-1:0] regs [NREG];
  logic [NREG-1:0] busy;
  logic            wr_live;

  function automatic logic idx_ok(input logic [AW-1:0] a);
    return int'(a) < NREG;
  endfunction

  function automatic logic busy_at(input logic [AW-1:0] a);
    return idx_ok(a) ? busy[a] : 1'b0;
  endfunction

  assign wr_live = bus.wr_en && (bus.wr_addr != '0) && idx_ok(bus.wr_addr);

  // Bypass is suppressed while reset is held so outputs read zero throughout reset.
  function automatic logic [XLEN-1:0] rd_val(input logic [AW-1:0] a);
    if (rst || !idx_ok(a) || a == '0) return '0;
    if (wr_live && bus.wr_addr == a) return bus.wr_data;
    return regs[a];
  endfunction

  always_comb begin
    bus.rd_data = '0;
    bus.rd_busy = '0;
    for (int i = 0; i < NRD; i++) begin
      bus.rd_data[i*XLEN +: XLEN] = rd_val(bus.rd_addr[i*AW +: AW]);
      bus.rd_busy[i] = busy_at(bus.rd_addr[i*AW +: AW]) &&
                       !(bus.wr_en && bus.wr_addr == bus.rd_addr[i*AW +: AW]);
    end
  end

  assign bus.rsv_ok = bus.rsv_en && idx_ok(bus.rsv_addr) &&
                      ((bus.rsv_addr == '0) || !busy_at(bus.rsv_addr) ||
                       (bus.wr_en && bus.wr_addr == bus.rsv_addr));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy <= '0;
      for (int r = 0; r < NREG; r++) regs[r] <= '0;
    end else begin
      if (wr_live) begin
        regs[bus.wr_addr] <= bus.wr_data;
        busy[bus.wr_addr] <= 1'b0;
      end
      // Later assignment lets a same-register reservation override the clear.
      if (bus.rsv_ok && bus.rsv_addr != '0) busy[bus.rsv_addr] <= 1'b1;
    end
  end

  assign bus.busy_vec = busy;

  always_comb begin
    bus.busy_cnt = '0;
    for (int r = 0; r < NREG; r++) bus.busy_cnt = bus.busy_cnt + CW'(busy[r]);
  end
endmodule

// File: tb/tb_regfile_sb.sv
// Randomized and directed bench for regfile_sb against an array-based reference model.
module tb_regfile_sb;
  localparam int XLEN = 32;
  localparam int NREG = 32;
  localparam int NRD  = 2;
  localparam int AW   = 5;

  logic clk = 1'b0;
  logic rst;
  int   n_chk = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  regfile_sb_if #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD)) bus ();
  regfile_sb #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD)) dut (.clk(clk), .rst(rst), .bus(bus));

  regfile_sb_if #(.XLEN(XLEN), .NREG(24), .NRD(1)) bus24 ();
  regfile_sb #(.XLEN(XLEN), .NREG(24), .NRD(1)) dut24 (.clk(clk), .rst(rst), .bus(bus24));

  logic [XLEN-1:0] mreg [NREG];
  logic [NREG-1:0] mbusy;
  logic            t_wr_en, t_rsv_en;
  logic [AW-1:0]   t_wr_addr, t_rsv_addr;
  logic [XLEN-1:0] t_wr_data;
  logic [AW-1:0]   t_rd [NRD];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_chk++;
    if (obs !== expv) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  task automatic mreset();
    for (int r = 0; r < NREG; r++) mreg[r] = '0;
    mbusy = '0;
  endtask

  function automatic bit exp_ok();
    return t_rsv_en && (t_rsv_addr == 0 || !mbusy[t_rsv_addr] ||
                        (t_wr_en && t_wr_addr == t_rsv_addr));
  endfunction

  task automatic check_comb(input string tag);
    logic [XLEN-1:0] ed;
    bit eb;
    int a;
    for (int i = 0; i < NRD; i++) begin
      a  = int'(t_rd[i]);
      if (rst || a == 0) ed = '0;
      else if (t_wr_en && int'(t_wr_addr) == a) ed = t_wr_data;
      else ed = mreg[a];
      eb = mbusy[a] && !(t_wr_en && int'(t_wr_addr) == a);
      chk($sformatf("%s.rd_data%0d", tag, i), 64'(bus.rd_data[i*XLEN +: XLEN]), 64'(ed));
      chk($sformatf("%s.rd_busy%0d", tag, i), 64'(bus.rd_busy[i]), 64'(eb));
    end
    chk({tag, ".rsv_ok"}, 64'(bus.rsv_ok), 64'(exp_ok()));
    chk({tag, ".busy_vec"}, 64'(bus.busy_vec), 64'(mbusy));
    chk({tag, ".busy_cnt"}, 64'(bus.busy_cnt), 64'($countones(mbusy)));
  endtask

  task automatic drive(input bit we, input int wa, input logic [XLEN-1:0] wd,
                       input bit re, input int ra, input int r0, input int r1,
                       input string tag);
    t_wr_en = we; t_wr_addr = AW'(wa); t_wr_data = wd;
    t_rsv_en = re; t_rsv_addr = AW'(ra);
    t_rd[0] = AW'(r0); t_rd[1] = AW'(r1);
    bus.wr_en = t_wr_en; bus.wr_addr = t_wr_addr; bus.wr_data = t_wr_data;
    bus.rsv_en = t_rsv_en; bus.rsv_addr = t_rsv_addr;
    bus.rd_addr = {t_rd[1], t_rd[0]};
    #1;
    check_comb(tag);
  endtask

  task automatic tick();
    bit ok;
    ok = exp_ok();
    @(posedge clk);
    if (!rst) begin
      if (t_wr_en && t_wr_addr != 0) begin
        mreg[t_wr_addr]  = t_wr_data;
        mbusy[t_wr_addr] = 1'b0;
      end
      if (ok && t_rsv_addr != 0) mbusy[t_rsv_addr] = 1'b1;
    end
    @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    mreset();
    bus24.wr_en = 1'b0; bus24.wr_addr = '0; bus24.wr_data = '0;
    bus24.rsv_en = 1'b0; bus24.rsv_addr = '0; bus24.rd_addr = '0;
    @(negedge clk);
    // Inside reset: bypass must stay hidden, reservation still answered.
    drive(1, 4, 32'h55, 1, 4, 4, 0, "in_rst");
    tick();
    rst = 1'b0;

    for (int a = 0; a < 32; a++) begin
      drive(0, 0, 0, 0, 0, a, 31 - a, "zero_rd");
      tick();
    end
    chk("zero_cnt", 64'(bus.busy_cnt), 64'd0);

    drive(0, 0, 0, 1, 5, 5, 0, "rsv5a");
    chk("rsv5_ok1", 64'(bus.rsv_ok), 64'd1);
    tick();
    drive(0, 0, 0, 1, 5, 5, 0, "rsv5b");
    chk("rsv5_ok2", 64'(bus.rsv_ok), 64'd0);
    chk("rsv5_busy", 64'(bus.rd_busy[0]), 64'd1);
    tick();
    drive(1, 5, 32'hDEADBEEF, 0, 0, 5, 5, "wr5");
    chk("wr5_byp", 64'(bus.rd_data[XLEN-1:0]), 64'hDEADBEEF);
    chk("wr5_rdbusy", 64'(bus.rd_busy[0]), 64'd0);
    tick();
    drive(0, 0, 0, 0, 0, 5, 0, "wr5_after");
    chk("wr5_vec", 64'(bus.busy_vec[5]), 64'd0);
    chk("wr5_rd", 64'(bus.rd_data[XLEN-1:0]), 64'hDEADBEEF);
    tick();

    drive(0, 0, 0, 1, 7, 7, 0, "rsv7");
    tick();
    drive(1, 7, 32'h1234, 1, 7, 7, 0, "wr_rsv7");
    chk("wr_rsv7_ok", 64'(bus.rsv_ok), 64'd1);
    tick();
    drive(0, 0, 0, 0, 0, 7, 0, "wr_rsv7_after");
    chk("x7_data", 64'(bus.rd_data[XLEN-1:0]), 64'h1234);
    chk("x7_busy", 64'(bus.busy_vec[7]), 64'd1);
    chk("x7_cnt", 64'(bus.busy_cnt), 64'd1);
    tick();

    drive(1, 0, 32'hFFFFFFFF, 1, 0, 0, 0, "x0");
    chk("x0_ok", 64'(bus.rsv_ok), 64'd1);
    chk("x0_rd", 64'(bus.rd_data[XLEN-1:0]), 64'd0);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, "x0_after");
    chk("x0_vec", 64'(bus.busy_vec[0]), 64'd0);
    tick();

    drive(1, 3, 32'hA5A5A5A5, 0, 0, 3, 0, "wr3"); tick();
    drive(1, 9, 32'h99, 0, 0, 9, 0, "wr9"); tick();
    for (int r = 1; r < 32; r++) begin
      drive(0, 0, 0, 1, r, r, 3, "fill");
      tick();
    end
    chk("fill_cnt", 64'(bus.busy_cnt), 64'd31);
    drive(1, 9, 32'h77, 1, 0, 3, 9, "pre_rst");
    #2;
    rst = 1'b1;
    mreset();
    #1;
    check_comb("async_rst");
    chk("arst_cnt", 64'(bus.busy_cnt), 64'd0);
    chk("arst_rd3", 64'(bus.rd_data[XLEN-1:0]), 64'd0);
    chk("arst_rd9", 64'(bus.rd_data[2*XLEN-1:XLEN]), 64'd0);
    tick();
    rst = 1'b0;
    drive(0, 0, 0, 0, 0, 3, 9, "post_rst");
    chk("post_rst_rd9", 64'(bus.rd_data[2*XLEN-1:XLEN]), 64'd0);
    tick();

    bus24.wr_en = 1'b1; bus24.wr_addr = 5'd30; bus24.wr_data = 32'hCAFE;
    bus24.rsv_en = 1'b1; bus24.rsv_addr = 5'd30; bus24.rd_addr = 5'd30;
    #1;
    chk("n24_ok30", 64'(bus24.rsv_ok), 64'd0);
    chk("n24_byp30", 64'(bus24.rd_data), 64'd0);
    @(posedge clk); @(negedge clk);
    bus24.wr_en = 1'b0; bus24.rsv_en = 1'b0;
    #1;
    chk("n24_rd30", 64'(bus24.rd_data), 64'd0);
    chk("n24_vec", 64'(bus24.busy_vec), 64'd0);
    bus24.wr_en = 1'b1; bus24.wr_addr = 5'd23; bus24.wr_data = 32'hBEEF;
    bus24.rsv_en = 1'b1; bus24.rsv_addr = 5'd23; bus24.rd_addr = 5'd23;
    #1;
    chk("n24_ok23", 64'(bus24.rsv_ok), 64'd1);
    chk("n24_byp23", 64'(bus24.rd_data), 64'hBEEF);
    @(posedge clk); @(negedge clk);
    bus24.wr_en = 1'b0; bus24.rsv_en = 1'b0;
    #1;
    chk("n24_rd23", 64'(bus24.rd_data), 64'hBEEF);
    chk("n24_cnt", 64'(bus24.busy_cnt), 64'd1);
    chk("n24_rdbusy", 64'(bus24.rd_busy), 64'd1);
    @(negedge clk);

    for (int n = 0; n < 1500; n++) begin
      int wa, ra, r0, r1;
      wa = $urandom_range(0, 31);
      ra = ($urandom_range(0, 3) == 0) ? wa : $urandom_range(0, 31);
      r0 = ($urandom_range(0, 3) == 0) ? wa : $urandom_range(0, 31);
      r1 = ($urandom_range(0, 3) == 0) ? ra : $urandom_range(0, 31);
      drive(1'($urandom_range(0, 1)), wa, $urandom, 1'($urandom_range(0, 1)), ra, r0, r1, "rnd");
      if (n % 300 == 150) begin
        #2;
        rst = 1'b1;
        mreset();
        #1;
        check_comb("rnd_rst");
        tick();
        rst = 1'b0;
      end else begin
        tick();
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
